// File: rtl/b5_mult_pkg.sv
// Shared constants for the b5 4x4 array multiplier tile.
// Operand/product widths and the positions of the operand fields in ui_in.
package b5_mult_pkg;

  localparam int OPW   = 4;
  localparam int PRW   = 2 * OPW;
  localparam int A_LSB = 0;
  localparam int B_LSB = 4;

  // Number of adder rows in the array (one per multiplier bit beyond bit 0)
  localparam int ROWS  = OPW - 1;

endpackage

// File: rtl/b5_full_adder.sv
// One-bit full adder cell used throughout the multiplier array.
// Half-adder positions tie cin low instead of using a separate cell.
module b5_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/b5_array_multiplier.sv
// 4x4 unsigned array multiplier TinyTapeout tile.
// ui_in[3:0] = A, ui_in[7:4] = B; uo_out = registered A*B.
// Each adder row is a 4-bit ripple adder that adds the next partial-product
// row to the upper bits of the running sum; the low bit of each row retires
// straight into the product.
// Optional macro B5_MULT_PIPE_EN inserts a register stage after adder row 1,
// making the latency two enabled cycles with identical product values.
module b5_array_multiplier
  import b5_mult_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [OPW-1:0] op_a;
  logic [OPW-1:0] op_b;
  logic [OPW-1:0] pp0;
  logic [OPW-1:0] pp1;

  logic [OPW-1:0] row_in_a [ROWS];
  logic [OPW-1:0] row_in_b [ROWS];
  logic [OPW-1:0] row_sum  [ROWS];
  logic [OPW:0]   row_cy   [ROWS];

  // Values crossing from adder row 1 into rows 2 and 3
  logic [OPW-1:0] s2_sum;
  logic           s2_cy;
  logic           s2_p0;
  logic [OPW-1:0] s2_a;
  logic [1:0]     s2_bhi;

  logic [PRW-1:0] product_d;
  logic [PRW-1:0] product_q;

  // The bidirectional bus is unused, so its input is deliberately dropped
  logic unused_uio_in;
  assign unused_uio_in = ^uio_in;

  assign op_a = ui_in[A_LSB +: OPW];
  assign op_b = ui_in[B_LSB +: OPW];
  assign pp0  = op_a & {OPW{op_b[0]}};
  assign pp1  = op_a & {OPW{op_b[1]}};

  // Row 1 adds pp1 to pp0 shifted down by one; rows 2 and 3 take the
  // previous row's carry-out as their top input bit
  assign row_in_a[0] = {1'b0, pp0[OPW-1:1]};
  assign row_in_b[0] = pp1;
  assign row_in_a[1] = {s2_cy, s2_sum[OPW-1:1]};
  assign row_in_b[1] = s2_a & {OPW{s2_bhi[0]}};
  assign row_in_a[2] = {row_cy[1][OPW], row_sum[1][OPW-1:1]};
  assign row_in_b[2] = s2_a & {OPW{s2_bhi[1]}};

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign row_cy[r][0] = 1'b0;
    for (genvar j = 0; j < OPW; j++) begin : g_col
      b5_full_adder u_fa (
        .a    (row_in_a[r][j]),
        .b    (row_in_b[r][j]),
        .cin  (row_cy[r][j]),
        .sum  (row_sum[r][j]),
        .cout (row_cy[r][j+1])
      );
    end
  end

`ifdef B5_MULT_PIPE_EN
  logic [OPW-1:0] mid_sum_d, mid_sum_q;
  logic           mid_cy_d,  mid_cy_q;
  logic           mid_p0_d,  mid_p0_q;
  logic [OPW-1:0] mid_a_d,   mid_a_q;
  logic [1:0]     mid_bhi_d, mid_bhi_q;

  // Mid-array stage loads row 1 results and the operand bits rows 2-3 need
  always_comb begin
    mid_sum_d = mid_sum_q;
    mid_cy_d  = mid_cy_q;
    mid_p0_d  = mid_p0_q;
    mid_a_d   = mid_a_q;
    mid_bhi_d = mid_bhi_q;
    if (ena) begin
      mid_sum_d = row_sum[0];
      mid_cy_d  = row_cy[0][OPW];
      mid_p0_d  = pp0[0];
      mid_a_d   = op_a;
      mid_bhi_d = op_b[3:2];
    end
  end

  // Mid-array stage register, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid_sum_q <= '0;
      mid_cy_q  <= 1'b0;
      mid_p0_q  <= 1'b0;
      mid_a_q   <= '0;
      mid_bhi_q <= '0;
    end else begin
      mid_sum_q <= mid_sum_d;
      mid_cy_q  <= mid_cy_d;
      mid_p0_q  <= mid_p0_d;
      mid_a_q   <= mid_a_d;
      mid_bhi_q <= mid_bhi_d;
    end
  end

  assign s2_sum = mid_sum_q;
  assign s2_cy  = mid_cy_q;
  assign s2_p0  = mid_p0_q;
  assign s2_a   = mid_a_q;
  assign s2_bhi = mid_bhi_q;
`else
  assign s2_sum = row_sum[0];
  assign s2_cy  = row_cy[0][OPW];
  assign s2_p0  = pp0[0];
  assign s2_a   = op_a;
  assign s2_bhi = op_b[3:2];
`endif

  // Assemble the product and hold the register whenever the tile is disabled
  always_comb begin
    product_d = product_q;
    if (ena) begin
      product_d = {row_cy[2][OPW], row_sum[2], row_sum[1][0], s2_sum[0], s2_p0};
    end
  end

  // Output product register, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q <= '0;
    end else begin
      product_q <= product_d;
    end
  end

  assign uo_out  = product_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_b5_array_multiplier.sv
// Directed testbench for the b5 4x4 array multiplier tile.
// Latency follows B5_MULT_PIPE_EN so the same bench covers both builds.
module tb_b5_array_multiplier;

`ifdef B5_MULT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rstN;
  logic       ena;
  logic [7:0] uiIn;
  logic [7:0] uioIn;
  logic [7:0] uoOut;
  logic [7:0] uioOut;
  logic [7:0] uioOe;

  int totalChecks  = 0;
  int passedChecks = 0;

  b5_array_multiplier dut (
    .clk     (clk),
    .rst_n   (rstN),
    .ena     (ena),
    .ui_in   (uiIn),
    .uio_in  (uioIn),
    .uo_out  (uoOut),
    .uio_out (uioOut),
    .uio_oe  (uioOe)
  );

  // Free-running 10-unit clock; inputs change and outputs are sampled on the falling edge
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepEdge();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive operands and enable with fresh random uio_in, then advance some edges
  task automatic applyStimulus(input logic [7:0] ui, input logic en, input int edges);
    uiIn  = ui;
    ena   = en;
    uioIn = 8'($urandom);
    repeat (edges) stepEdge();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expected);
    totalChecks++;
    assert (uoOut === expected) passedChecks++;
    else $error("[TB] FAIL %s: uo_out observed %h expected %h", tag, uoOut, expected);
  endtask

  task automatic checkTies(input string tag);
    totalChecks++;
    assert ({uioOut, uioOe} === 16'h0000) passedChecks++;
    else $error("[TB] FAIL %s: uio_out/uio_oe observed %h/%h expected 00/00", tag, uioOut, uioOe);
  endtask

  // Directed sequence: reset, corner products, hold, then a full sweep with a mid-sweep reset
  initial begin
    logic [7:0] v;
    logic [7:0] expProd;
    rstN  = 1'b1;
    ena   = 1'b0;
    uiIn  = 8'h00;
    uioIn = 8'h00;
    #1;
    rstN = 1'b0;
    uiIn = 8'hFF;
    #1;
    checkOutput("resetNoEdge", 8'h00);
    checkTies("resetTies");
    @(negedge clk);
    checkOutput("resetAfterEdge", 8'h00);
    rstN = 1'b1;

    applyStimulus(8'hFF, 1'b1, LAT);
    checkOutput("max15x15", 8'hE1);
    applyStimulus(8'h53, 1'b1, LAT);
    checkOutput("basic3x5", 8'h0F);
    applyStimulus(8'h0A, 1'b1, LAT);
    checkOutput("zero10x0", 8'h00);
    applyStimulus(8'hA0, 1'b1, LAT);
    checkOutput("zero0x10", 8'h00);
    applyStimulus(8'hC7, 1'b1, LAT);
    checkOutput("basic7x12", 8'h54);

    applyStimulus(8'h53, 1'b1, LAT);
    checkOutput("holdLoad", 8'h0F);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'hFF, 1'b0, 1);
      checkOutput("holdDisabled", 8'h0F);
    end
    applyStimulus(8'hFF, 1'b1, LAT);
    checkOutput("holdResume", 8'hE1);

    $display("[TB] exhaustive sweep, latency %0d", LAT);
    for (int n = 0; n < 256; n++) begin
      v = 8'(n);
      if (n == 128) begin
        rstN = 1'b0;
        #1;
        checkOutput("midSweepReset", 8'h00);
        @(negedge clk);
        checkOutput("midSweepResetHeld", 8'h00);
        rstN = 1'b1;
      end
      expProd = 8'(v[3:0] * v[7:4]);
      applyStimulus(v, 1'b1, LAT);
      checkOutput($sformatf("sweep%02h", v), expProd);
      checkTies("sweepTies");
    end

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
